// File: rtl/shared_timer_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// shared_timer_arbiter_pkg
//   Shared constants for the shared seconds timer and its mode-controller
//   clients: requester count, requester index assignments, the arbiter FSM
//   state encoding and the clean-mode countdown length.
//   No ports (package).
// ---------------------------------------------------------------------------
package shared_timer_arbiter_pkg;

    // Number of controllers sharing the timer and their fixed request slots.
    localparam int TIMER_N_REQ        = 4;
    localparam int REQ_CLEAN_EXIT     = 0;
    localparam int REQ_HURRICANE_EXIT = 1;
    localparam int REQ_SETTINGS_TO    = 2;
    localparam int REQ_REMIND         = 3;

    // Clean-mode countdown length in seconds.
    localparam int CLEAN_MODE_COUNTER_TIME = 30;

    // Arbiter FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage : shared_timer_arbiter_pkg

// File: rtl/timer_tick_prescaler.sv
// ---------------------------------------------------------------------------
// timer_tick_prescaler
//   Free-running 0..TICK_DIV-1 counter that raises tick for one cycle when it
//   reaches TICK_DIV-1. clear forces the count back to 0 so the first tick of
//   a countdown always lands a full TICK_DIV cycles after clear drops.
//   Ports:
//     clk    in   clock
//     rst    in   synchronous reset, active-high
//     clear  in   hold/restart the count at 0
//     tick   out  one-cycle pulse every TICK_DIV cycles while not cleared
// ---------------------------------------------------------------------------
module timer_tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick  = (cnt_q == PW'(TICK_DIV - 1));
    assign cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : timer_tick_prescaler

// File: rtl/shared_timer_arbiter.sv
// ---------------------------------------------------------------------------
// shared_timer_arbiter
//   One down-counting seconds timer shared round-robin among N_REQ mode
//   controllers. The granted controller's load value is counted down once per
//   prescaler tick; it receives a one-cycle done pulse on expiry. Ownership is
//   non-preemptive; dropping req while running abandons the countdown.
//   Ports:
//     clk         in   clock
//     rst         in   synchronous reset, active-high (beats flush)
//     flush       in   mode-change abort, back to IDLE from any state
//     req         in   level requests, one per controller
//     load_value  in   flat bus, slice i = [i*CNT_WIDTH +: CNT_WIDTH]
//     grant       out  one-hot owner, 0 when idle
//     done        out  one-cycle expiry pulse to the owner
//     busy        out  high in LOAD, RUN and DONE
//     remain      out  current count, 0 when idle (SHARED_TIMER_REMAIN_EN only)
//   Build option: define SHARED_TIMER_REMAIN_EN to add the remain port.
// ---------------------------------------------------------------------------
`ifndef MAX_WIDTH
`define MAX_WIDTH 16
`endif

module shared_timer_arbiter
    import shared_timer_arbiter_pkg::*;
#(
    parameter int N_REQ     = TIMER_N_REQ,
    parameter int CNT_WIDTH = `MAX_WIDTH,
    parameter int TICK_DIV  = 100_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*CNT_WIDTH-1:0] load_value,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           done,
    output logic                       busy
`ifdef SHARED_TIMER_REMAIN_EN
    ,
    output logic [CNT_WIDTH-1:0]       remain
`endif
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e               state_q, state_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic                 tick;
    logic                 pre_clear;
    logic [OW-1:0]        pick;
    logic                 pick_valid;
    logic [OW-1:0]        next_ptr;
    int                   scan_idx;
    logic [OW-1:0]        scan_sel;
    logic [CNT_WIDTH-1:0] load_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign load_arr[i] = load_value[i*CNT_WIDTH +: CNT_WIDTH];
    end

    // The prescaler only runs in RUN, so each countdown starts from phase 0.
    assign pre_clear = flush || (state_q != ST_RUN);

    timer_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (pre_clear),
        .tick  (tick)
    );

    // Round-robin pick: scan offsets from high to low so the lowest offset
    // from rr_ptr (the first set bit upward with wrap) is the one that sticks.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        scan_idx   = 0;
        scan_sel   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = (int'(rr_ptr_q) + k) % N_REQ;
            scan_sel = OW'(scan_idx);
            if (req[scan_sel]) begin
                pick       = scan_sel;
                pick_valid = 1'b1;
            end
        end
    end

    assign next_ptr = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + 1'b1;

    // NOTE: every combinational output gets a default first, so no path through
    // the case statement leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        count_d  = count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    owner_d       = pick;
                    state_d       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = load_arr[owner_q];
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Expiry is detected on count==0 inside RUN, so a zero load and
                // a normal expiry share the same path and the grant-to-done
                // latency is load*TICK_DIV + 2 for every load value.
                if (!req[owner_q]) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    count_d  = '0;
                    rr_ptr_d = next_ptr;
                end else if (count_q == '0) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    count_d = count_q - 1'b1;
                end
            end
            ST_DONE: begin
                grant_d  = '0;
                rr_ptr_d = next_ptr;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                count_d = '0;
            end
        endcase

        // Abort keeps the round-robin position so the interrupted owner is
        // not skipped.
        if (flush) begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            count_d  = '0;
            rr_ptr_d = rr_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            count_q  <= count_d;
        end
    end

    assign grant = grant_q;
    assign done  = (state_q == ST_DONE) ? grant_q : '0;
    assign busy  = (state_q != ST_IDLE);

`ifdef SHARED_TIMER_REMAIN_EN
    assign remain = count_q;
`endif

endmodule : shared_timer_arbiter
